// File: rtl/tl_ul_master_port.sv
// TL-UL single-beat master port: turns local read/write commands into A beats and D beats into responses.
// Optional macro TL_UL_MASTER_PORT_RSP_SKID_EN registers the response path through a 1-entry skid buffer.
module tl_ul_master_port #(
  parameter int SOURCE_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [1:0]          req_size,
  input  logic [3:0]          req_mask,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_write,
  output logic                rsp_error,
  output logic [SOURCE_W-1:0] rsp_source,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [2:0]          a_opcode,
  output logic [2:0]          a_param,
  output logic [1:0]          a_size,
  output logic [SOURCE_W-1:0] a_source,
  output logic [31:0]         a_address,
  output logic [3:0]          a_mask,
  output logic [31:0]         a_data,
  output logic                a_corrupt,
  input  logic                d_valid,
  output logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [1:0]          d_param,
  input  logic [1:0]          d_size,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic                d_sink,
  input  logic [31:0]         d_data,
  input  logic                d_denied,
  input  logic                d_corrupt,
  output logic                busy,
  output logic                err_unexp
);

  localparam int NSRC = 1 << SOURCE_W;

  logic [NSRC-1:0]     free_q, free_d;
  logic                errUnexp_q, errUnexp_d;
  logic                busy_q;
  logic                avail;
  logic [SOURCE_W-1:0] alloc;
  logic                aFire, dFire;
  logic [31:0]         dRdata;
  logic                dWrite, dError;
  logic                unusedDBits;

  assign unusedDBits = ^{d_param, d_size, d_sink};

  // Allocation looks only at the registered vector, so a source freed this cycle is reused next cycle at the earliest.
  always_comb begin
    alloc = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (free_q[i]) alloc = SOURCE_W'(i);
    end
  end

  assign avail     = |free_q;
  assign a_valid   = req_valid & avail & ~reset;
  assign req_ready = a_ready & avail & ~reset;
  assign aFire     = a_valid & a_ready;
  assign dFire     = d_valid & d_ready;

  always_comb begin
    if (!req_write)                               a_opcode = 3'd4;
    else if (req_size == 2'd2 && req_mask == 4'hF) a_opcode = 3'd0;
    else                                          a_opcode = 3'd1;
  end

  assign a_param   = 3'd0;
  assign a_corrupt = 1'b0;
  assign a_source  = alloc;
  assign a_size    = req_size;
  assign a_address = req_addr;
  assign a_mask    = req_mask;
  assign a_data    = req_wdata;

  // A spurious D on the source being allocated must not undo that allocation, so the A clear wins.
  always_comb begin
    free_d = free_q;
    if (dFire) free_d[d_source] = 1'b1;
    if (aFire) free_d[alloc] = 1'b0;
    errUnexp_d = errUnexp_q | (dFire & free_q[d_source]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_q     <= '1;
      errUnexp_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      free_q     <= free_d;
      errUnexp_q <= errUnexp_d;
      busy_q     <= ~&free_d;
    end
  end

  assign busy      = busy_q;
  assign err_unexp = errUnexp_q;

  assign dRdata = (d_opcode == 3'd1) ? d_data : 32'd0;
  assign dWrite = (d_opcode == 3'd0);
  assign dError = d_denied | d_corrupt;

`ifdef TL_UL_MASTER_PORT_RSP_SKID_EN
  logic                skidFull_q, skidFull_d;
  logic [31:0]         skidRdata_q;
  logic                skidWrite_q, skidError_q;
  logic [SOURCE_W-1:0] skidSource_q;

  assign d_ready    = (~skidFull_q | rsp_ready) & ~reset;
  assign skidFull_d = dFire | (skidFull_q & ~rsp_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skidFull_q   <= 1'b0;
      skidRdata_q  <= '0;
      skidWrite_q  <= 1'b0;
      skidError_q  <= 1'b0;
      skidSource_q <= '0;
    end else begin
      skidFull_q <= skidFull_d;
      if (dFire) begin
        skidRdata_q  <= dRdata;
        skidWrite_q  <= dWrite;
        skidError_q  <= dError;
        skidSource_q <= d_source;
      end
    end
  end

  assign rsp_valid  = skidFull_q;
  assign rsp_rdata  = skidRdata_q;
  assign rsp_write  = skidWrite_q;
  assign rsp_error  = skidError_q;
  assign rsp_source = skidSource_q;
`else
  assign d_ready    = rsp_ready & ~reset;
  assign rsp_valid  = d_valid & ~reset;
  assign rsp_rdata  = dRdata;
  assign rsp_write  = dWrite;
  assign rsp_error  = dError;
  assign rsp_source = d_source;
`endif

endmodule
